// File: rtl/mem_port_arbiter_if.sv
// Shared RAM port bundle: fetch and data requester
// channels plus the external RAM command/return bus.
interface mem_port_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int RAM_WIDTH  = 32
);
  logic                  if_req;
  logic [WORD_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [RAM_WIDTH-1:0]  if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [WORD_WIDTH-1:0] dm_addr;
  logic [RAM_WIDTH-1:0]  dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [RAM_WIDTH-1:0]  dm_rdata;

  logic                  ram_read;
  logic                  ram_write;
  logic [WORD_WIDTH-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]  ram_wdata;
  logic [RAM_WIDTH-1:0]  ram_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  ram_read, ram_write, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output ram_read, ram_write, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by fetch and data requesters;
// data-first priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int WORD_WIDTH      = 32,
  parameter int RAM_WIDTH       = 32,
  parameter int RAM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT
  } state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [3:0] LP_LAT = 4'(RAM_LATENCY - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;
  logic [3:0] r_lat;
  logic r_owner_dm;
  logic r_we;
  logic w_go;
  logic w_pick_dm;
  logic w_pick_we;
  logic w_done;

  logic                  r_if_gnt;
  logic                  r_dm_gnt;
  logic                  r_if_rvalid;
  logic                  r_dm_rvalid;
  logic [RAM_WIDTH-1:0]  r_if_rdata;
  logic [RAM_WIDTH-1:0]  r_dm_rdata;
  logic                  r_ram_read;
  logic                  r_ram_write;
  logic [WORD_WIDTH-1:0] r_ram_addr;
  logic [RAM_WIDTH-1:0]  r_ram_wdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_go         = 1'b0;
    w_pick_dm    = 1'b0;
    w_pick_we    = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_go      = bus.if_req | bus.dm_req;
        w_pick_dm = bus.dm_req &
                    ~(bus.if_req & (r_streak == LP_MAX));
        w_pick_we = w_pick_dm & bus.dm_we;
        if (w_go) w_state_nxt = S_CMD;
        // streak only counts data wins that made fetch wait
        if (!bus.if_req || !w_pick_dm)
          w_streak_nxt = '0;
        else if (r_streak != LP_MAX)
          w_streak_nxt = r_streak + 4'd1;
      end
      S_CMD: w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT: begin
        w_done = (r_lat == 4'd0);
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat       <= '0;
      r_owner_dm  <= 1'b0;
      r_we        <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_if_gnt    <= w_go & ~w_pick_dm;
      r_dm_gnt    <= w_go & w_pick_dm;
      r_ram_read  <= w_go & ~w_pick_we;
      r_ram_write <= w_go & w_pick_we;
      r_ram_addr  <= !w_go    ? '0 :
                     w_pick_dm ? bus.dm_addr : bus.if_addr;
      r_ram_wdata <= w_pick_we ? bus.dm_wdata : '0;
      r_if_rvalid <= w_done & ~r_owner_dm;
      r_dm_rvalid <= w_done & r_owner_dm;
      if (w_go) begin
        r_owner_dm <= w_pick_dm;
        r_we       <= w_pick_we;
      end
      if (r_state == S_CMD)
        r_lat <= LP_LAT;
      else if (r_state == S_WAIT && !w_done)
        r_lat <= r_lat - 4'd1;
      if (w_done && !r_owner_dm) r_if_rdata <= bus.ram_rdata;
      if (w_done && r_owner_dm)  r_dm_rdata <= bus.ram_rdata;
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.dm_gnt    = r_dm_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.ram_read  = r_ram_read;
  assign bus.ram_write = r_ram_write;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances at RAM
// latencies 1/3/4/8 sharing stimulus, one observed at a time.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  logic [3:0] o_if_gnt, o_dm_gnt, o_if_rv, o_dm_rv;
  logic [3:0] o_rd, o_wr;
  logic [31:0] o_if_rdata [4];
  logic [31:0] o_dm_rdata [4];
  logic [31:0] o_addr [4];
  logic [31:0] o_wdata [4];

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;
  logic [31:0] if_q [$];
  logic [31:0] dm_q [$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 :
                       (g == 2) ? 4 : 8;
    mem_port_arbiter_if bus ();
    logic pv [1:8];
    logic [31:0] pa [1:8];

    // RAM model: data valid exactly L cycles after the command
    always @(posedge clk) begin
      pv[1] <= bus.ram_read;
      pa[1] <= bus.ram_addr;
      for (int k = 2; k <= 8; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end

    assign bus.if_req    = if_req;
    assign bus.if_addr   = if_addr;
    assign bus.dm_req    = dm_req;
    assign bus.dm_we     = dm_we;
    assign bus.dm_addr   = dm_addr;
    assign bus.dm_wdata  = dm_wdata;
    assign bus.ram_rdata = pv[L] ? rom(pa[L]) : 32'hBAD00BAD;

    mem_port_arbiter #(
      .WORD_WIDTH(32), .RAM_WIDTH(32),
      .RAM_LATENCY(L), .MAX_DATA_STREAK(4)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );

    assign o_if_gnt[g]   = bus.if_gnt;
    assign o_dm_gnt[g]   = bus.dm_gnt;
    assign o_if_rv[g]    = bus.if_rvalid;
    assign o_dm_rv[g]    = bus.dm_rvalid;
    assign o_rd[g]       = bus.ram_read;
    assign o_wr[g]       = bus.ram_write;
    assign o_if_rdata[g] = bus.if_rdata;
    assign o_dm_rdata[g] = bus.dm_rdata;
    assign o_addr[g]     = bus.ram_addr;
    assign o_wdata[g]    = bus.ram_wdata;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle();
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
    if_q.delete(); dm_q.delete();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; tick(); tick();
    for (int g = 0; g < 4; g++) begin
      n_cmp++;
      if ({o_if_gnt[g], o_dm_gnt[g], o_if_rv[g], o_dm_rv[g],
           o_rd[g], o_wr[g], o_if_rdata[g], o_dm_rdata[g],
           o_addr[g], o_wdata[g]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: got nonzero outputs, want all 0", g);
      end
    end
    rst = 0;
  endtask

  task automatic test_fetch();
    logic [31:0] exp;
    sel = 0; if_q.delete();
    if_req = 1; if_addr = 32'h40;
    if_q.push_back(rom(32'h40));
    tick();
    n_cmp++;
    if (o_rd[sel] !== 1 || o_addr[sel] !== 32'h40 ||
        o_if_gnt[sel] !== 1 || o_wdata[sel] !== 0) begin
      n_bad++;
      $display("FAIL fetch_cmd: got rd=%b addr=%h gnt=%b wd=%h, want 1 00000040 1 0",
               o_rd[sel], o_addr[sel], o_if_gnt[sel], o_wdata[sel]);
    end
    if_req = 0;
    tick();
    n_cmp++;
    if (o_if_rv[sel] !== 0 || o_rd[sel] !== 0 || o_addr[sel] !== 0) begin
      n_bad++;
      $display("FAIL fetch_wait: got rv=%b rd=%b addr=%h, want 0 0 0",
               o_if_rv[sel], o_rd[sel], o_addr[sel]);
    end
    tick();
    n_cmp++;
    exp = if_q.pop_front();
    if (o_if_rv[sel] !== 1 || o_if_rdata[sel] !== exp) begin
      n_bad++;
      $display("FAIL fetch_rdata: got rv=%b data=%h, want 1 %h",
               o_if_rv[sel], o_if_rdata[sel], exp);
    end
  endtask

  task automatic test_write();
    logic seen;
    sel = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'h12345678;
    tick();
    n_cmp++;
    if (o_wr[sel] !== 1 || o_rd[sel] !== 0 || o_addr[sel] !== 32'h100 ||
        o_wdata[sel] !== 32'h12345678 || o_dm_gnt[sel] !== 1 ||
        o_if_gnt[sel] !== 0) begin
      n_bad++;
      $display("FAIL write_cmd: got wr=%b rd=%b addr=%h wd=%h gnt=%b, want 1 0 100 12345678 1",
               o_wr[sel], o_rd[sel], o_addr[sel], o_wdata[sel], o_dm_gnt[sel]);
    end
    dm_req = 0; dm_we = 0;
    tick();
    n_cmp++;
    if (o_wr[sel] !== 0 || o_wdata[sel] !== 0) begin
      n_bad++;
      $display("FAIL write_end: got wr=%b wd=%h, want 0 0", o_wr[sel], o_wdata[sel]);
    end
    seen = 0;
    repeat (5) begin
      seen |= o_dm_rv[sel];
      tick();
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL write_no_rvalid: got rvalid=%b, want 0", seen);
    end
  endtask

  task automatic test_simultaneous();
    int first, if_g_c, dm_v_c, got;
    logic [31:0] exp;
    sel = 0; if_q.delete(); dm_q.delete();
    first = 0; if_g_c = -1; dm_v_c = -1; got = 0;
    if_req = 1; if_addr = 32'h80;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    if_q.push_back(rom(32'h80));
    dm_q.push_back(rom(32'h200));
    for (int c = 1; c <= 30 && got < 2; c++) begin
      tick();
      if (o_dm_gnt[sel]) begin
        if (first == 0) first = 1;
        dm_req = 0;
      end
      if (o_if_gnt[sel]) begin
        if (first == 0) first = 2;
        if_g_c = c; if_req = 0;
      end
      if (o_dm_rv[sel]) begin
        dm_v_c = c; got++; n_cmp++;
        exp = (dm_q.size() != 0) ? dm_q.pop_front() : 32'hx;
        if (o_dm_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL sim_dm_rdata: got %h, want %h", o_dm_rdata[sel], exp);
        end
      end
      if (o_if_rv[sel]) begin
        got++; n_cmp++;
        exp = (if_q.size() != 0) ? if_q.pop_front() : 32'hx;
        if (o_if_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL sim_if_rdata: got %h, want %h", o_if_rdata[sel], exp);
        end
      end
    end
    set_idle();
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL sim_timeout: got %0d rvalids, want 2", got);
    end
    n_cmp++;
    if (first != 1) begin
      n_bad++;
      $display("FAIL sim_first_grant: got %0d, want 1 (data)", first);
    end
    n_cmp++;
    if (if_g_c != dm_v_c + 1) begin
      n_bad++;
      $display("FAIL sim_fetch_after_rvalid: got if_gnt cycle %0d, want %0d",
               if_g_c, dm_v_c + 1);
    end
  endtask

  task automatic test_starvation();
    int n_g;
    logic is_f;
    logic [31:0] exp;
    sel = 0; if_q.delete(); dm_q.delete();
    n_g = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'hCAFE0001;
    if_req = 1; if_addr = 32'h60;
    for (int c = 0; c < 150 && n_g < 10; c++) begin
      tick();
      if (o_if_rv[sel]) begin
        n_cmp++;
        exp = (if_q.size() != 0) ? if_q.pop_front() : 32'hx;
        if (o_if_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL starve_rdata: got %h, want %h", o_if_rdata[sel], exp);
        end
      end
      if (o_dm_gnt[sel] || o_if_gnt[sel]) begin
        is_f = o_if_gnt[sel];
        n_cmp++;
        if (is_f !== ((n_g % 5) == 4)) begin
          n_bad++;
          $display("FAIL starve_grant_%0d: got fetch=%b, want %b",
                   n_g, is_f, (n_g % 5) == 4);
        end
        if (is_f) if_q.push_back(rom(if_addr));
        n_g++;
      end
    end
    n_cmp++;
    if (n_g < 10) begin
      n_bad++;
      $display("FAIL starve_timeout: got %0d grants, want 10", n_g);
    end
    set_idle();
    repeat (12) begin
      tick();
      if (o_if_rv[sel] && if_q.size() != 0) begin
        n_cmp++;
        exp = if_q.pop_front();
        if (o_if_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL starve_drain: got %h, want %h", o_if_rdata[sel], exp);
        end
      end
    end
    n_cmp++;
    if (if_q.size() != 0) begin
      n_bad++;
      $display("FAIL starve_pending: got %0d unreturned reads, want 0", if_q.size());
    end
  endtask

  task automatic test_reset_wait();
    logic seen;
    int c_g, c_v;
    logic [31:0] exp;
    sel = 2; set_idle(); do_reset();
    if_req = 1; if_addr = 32'h44;
    if_q.push_back(rom(32'h44));
    tick();
    n_cmp++;
    if (o_if_gnt[sel] !== 1 || o_rd[sel] !== 1) begin
      n_bad++;
      $display("FAIL rstw_gnt: got gnt=%b rd=%b, want 1 1", o_if_gnt[sel], o_rd[sel]);
    end
    if_req = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    if_q.delete();
    n_cmp++;
    if ({o_if_gnt[sel], o_dm_gnt[sel], o_if_rv[sel], o_dm_rv[sel],
         o_rd[sel], o_wr[sel], o_if_rdata[sel], o_dm_rdata[sel],
         o_addr[sel], o_wdata[sel]} !== '0) begin
      n_bad++;
      $display("FAIL rstw_outputs: got nonzero outputs, want all 0");
    end
    seen = 0;
    repeat (12) begin
      seen |= o_if_rv[sel] | o_dm_rv[sel];
      tick();
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rstw_no_rvalid: got rvalid=%b, want 0", seen);
    end
    if_req = 1; if_addr = 32'h48;
    if_q.push_back(rom(32'h48));
    c_g = -1; c_v = -1;
    for (int c = 1; c <= 20 && c_v < 0; c++) begin
      tick();
      if (o_if_gnt[sel]) begin
        c_g = c; if_req = 0;
      end
      if (o_if_rv[sel]) begin
        c_v = c; n_cmp++;
        exp = if_q.pop_front();
        if (o_if_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL rstw_refetch_data: got %h, want %h", o_if_rdata[sel], exp);
        end
      end
    end
    n_cmp++;
    if (c_g != 1 || c_v != 6) begin
      n_bad++;
      $display("FAIL rstw_refetch_timing: got gnt@%0d rvalid@%0d, want 1 and 6",
               c_g, c_v);
    end
    set_idle();
  endtask

  task automatic test_sweep(input int s);
    logic busy;
    logic [31:0] exp;
    sel = s; set_idle(); do_reset();
    busy = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (o_rd[sel] || o_wr[sel]) begin
        n_cmp++;
        if (busy || (o_rd[sel] && o_wr[sel])) begin
          n_bad++;
          $display("FAIL sweep%0d_overlap: got rd=%b wr=%b busy=%b, want one cmd idle port",
                   s, o_rd[sel], o_wr[sel], busy);
        end
        busy = o_rd[sel];
      end
      if (o_if_gnt[sel]) begin
        n_cmp++;
        if (o_rd[sel] !== 1 || o_addr[sel] !== if_addr) begin
          n_bad++;
          $display("FAIL sweep%0d_if_cmd: got rd=%b addr=%h, want 1 %h",
                   s, o_rd[sel], o_addr[sel], if_addr);
        end
      end
      if (o_dm_gnt[sel]) begin
        n_cmp++;
        if (o_addr[sel] !== dm_addr || o_wr[sel] !== dm_we ||
            o_wdata[sel] !== (dm_we ? dm_wdata : 32'h0)) begin
          n_bad++;
          $display("FAIL sweep%0d_dm_cmd: got wr=%b addr=%h wd=%h, want %b %h %h",
                   s, o_wr[sel], o_addr[sel], o_wdata[sel], dm_we, dm_addr,
                   dm_we ? dm_wdata : 32'h0);
        end
      end
      if (o_if_rv[sel]) begin
        busy = 0; n_cmp++;
        exp = (if_q.size() != 0) ? if_q.pop_front() : 32'hx;
        if (o_if_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL sweep%0d_if_rdata: got %h, want %h", s, o_if_rdata[sel], exp);
        end
      end
      if (o_dm_rv[sel]) begin
        busy = 0; n_cmp++;
        exp = (dm_q.size() != 0) ? dm_q.pop_front() : 32'hx;
        if (o_dm_rdata[sel] !== exp) begin
          n_bad++;
          $display("FAIL sweep%0d_dm_rdata: got %h, want %h", s, o_dm_rdata[sel], exp);
        end
      end
      if (o_if_gnt[sel]) if_req = 0;
      if (o_dm_gnt[sel]) dm_req = 0;
      if (c < 300) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1;
          if_addr = 32'($urandom_range(0, 1023)) << 2;
          if_q.push_back(rom(if_addr));
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1;
          dm_we = 1'($urandom_range(0, 1));
          dm_addr = 32'($urandom_range(0, 1023)) << 2;
          dm_wdata = $urandom;
          if (!dm_we) dm_q.push_back(rom(dm_addr));
        end
      end
    end
    n_cmp++;
    if (if_req || dm_req || busy || if_q.size() != 0 || dm_q.size() != 0) begin
      n_bad++;
      $display("FAIL sweep%0d_drain: got if_q=%0d dm_q=%0d busy=%b, want all empty",
               s, if_q.size(), dm_q.size(), busy);
    end
    set_idle();
  endtask

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_fetch();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_wait();
    test_sweep(0);
    test_sweep(1);
    test_sweep(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
